// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_pkg
// Shared definitions for the MEM-stage load/store bus controller:
//   - access size encodings (mem_size_i / internal size fields)
//   - controller FSM state encodings
//   - bus timeout limit
//   - misalignment helper used when MEM_ALIGN_EXC_EN is defined
// -----------------------------------------------------------------------------
package mem_access_ctrl_pkg;

    // Access size encodings; 2'b11 behaves exactly like a word access.
    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } mem_size_e;

    // Controller FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Number of BUS cycles without ack before the access is abandoned.
    localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

    // True when an access of the given size is not naturally aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic res;
        case (size)
            SIZE_BYTE:               res = 1'b0;
            SIZE_HALF:               res = addr_lo[0];
            SIZE_WORD, SIZE_WORD_ALT: res = (addr_lo != 2'b00);
            default:                 res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// -----------------------------------------------------------------------------
// mem_lane_fmt
// Combinational little-endian byte-lane formatter.
// Store side: byte enables and write-data replication for the addressed lane.
// Load side : extraction of the addressed byte/half from the bus word and
//             sign/zero extension to 32 bits.
// Half accesses only look at addr[1]; word accesses ignore addr[1:0].
//
// Ports
//   i_st_size     [1:0]  store/issue access size
//   i_st_addr_lo  [1:0]  store/issue address low bits
//   i_st_wdata    [31:0] raw store data from the pipeline
//   o_st_be       [3:0]  byte enables
//   o_st_wdata    [31:0] replicated store data
//   i_ld_size     [1:0]  captured load size
//   i_ld_addr_lo  [1:0]  captured load address low bits
//   i_ld_signed          sign-extend the loaded value
//   i_ld_rdata    [31:0] raw bus read word
//   o_ld_data     [31:0] formatted load result
// -----------------------------------------------------------------------------
module mem_lane_fmt
    import mem_access_ctrl_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic        i_ld_signed,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    // Byte enables and write-data replication for the issuing access.
    always_comb begin
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_wdata;
        case (i_st_size)
            SIZE_BYTE: begin
                o_st_be    = 4'b0001 << i_st_addr_lo;
                o_st_wdata = {4{i_st_wdata[7:0]}};
            end
            SIZE_HALF: begin
                o_st_be    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_st_wdata = {2{i_st_wdata[15:0]}};
            end
            default: begin
                o_st_be    = 4'b1111;
                o_st_wdata = i_st_wdata;
            end
        endcase
    end

    // Select the addressed byte and halfword out of the read word.
    always_comb begin
        w_ld_byte = i_ld_rdata[7:0];
        case (i_ld_addr_lo)
            2'b00:   w_ld_byte = i_ld_rdata[7:0];
            2'b01:   w_ld_byte = i_ld_rdata[15:8];
            2'b10:   w_ld_byte = i_ld_rdata[23:16];
            2'b11:   w_ld_byte = i_ld_rdata[31:24];
            default: w_ld_byte = i_ld_rdata[7:0];
        endcase
        if (i_ld_addr_lo[1]) begin
            w_ld_half = i_ld_rdata[31:16];
        end else begin
            w_ld_half = i_ld_rdata[15:0];
        end
    end

    // Extend the selected lane to 32 bits.
    always_comb begin
        o_ld_data = i_ld_rdata;
        case (i_ld_size)
            SIZE_BYTE: begin
                if (i_ld_signed) begin
                    o_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
                end else begin
                    o_ld_data = {24'h000000, w_ld_byte};
                end
            end
            SIZE_HALF: begin
                if (i_ld_signed) begin
                    o_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
                end else begin
                    o_ld_data = {16'h0000, w_ld_half};
                end
            end
            default: o_ld_data = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// MEM-stage load/store controller bridging the pipeline to a single-beat bus.
// FSM IDLE -> BUS -> DONE -> IDLE. The request is captured in IDLE, the bus
// request is held stable in BUS until ack (or a 255-cycle timeout), and DONE
// produces a one-cycle done_o pulse with the formatted load data on rdata_o.
// A flush seen during BUS lets the bus transaction finish but returns to IDLE
// silently. Reset is synchronous, active-high.
//
// Optional feature: define MEM_ALIGN_EXC_EN to trap misaligned half/word
// accesses (no bus cycle, addr_exc_o pulses with done_o). Without it,
// misaligned accesses are issued with the low address bits ignored.
//
// Ports
//   clk, rst                       clock, sync active-high reset
//   mem_req_i, mem_we_i            access valid, store select
//   mem_size_i[1:0], mem_signed_i  size, load sign-extension
//   mem_addr_i[31:0], mem_wdata_i  address, store data
//   flush_i                        pipeline flush
//   bus_req_o, bus_we_o            bus request, write
//   bus_addr_o[31:0], bus_be_o[3:0], bus_wdata_o[31:0]
//   bus_ack_i, bus_rdata_i[31:0]   bus completion, read data
//   stallreq_o                     combinational pipeline stall
//   done_o, rdata_o[31:0]          completion pulse, formatted load data
//   bus_err_o, addr_exc_o          timeout pulse, misalignment pulse
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_signed_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stallreq_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        bus_err_o,
    output logic        addr_exc_o
);

    state_e      r_state;
    logic [7:0]  r_cnt;
    logic        r_flushed;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_addr_lo;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic        r_done;
    logic [31:0] r_rdata;
    logic        r_bus_err;
    logic        r_addr_exc;

    state_e      w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic        w_flushed_nxt;
    logic [1:0]  w_size_nxt;
    logic        w_signed_nxt;
    logic [1:0]  w_addr_lo_nxt;
    logic        w_bus_req_nxt;
    logic        w_bus_we_nxt;
    logic [31:0] w_bus_addr_nxt;
    logic [3:0]  w_bus_be_nxt;
    logic [31:0] w_bus_wdata_nxt;
    logic        w_done_nxt;
    logic [31:0] w_rdata_nxt;
    logic        w_bus_err_nxt;
    logic        w_addr_exc_nxt;

    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;
    logic [31:0] w_ld_data;
    logic        w_misaligned;
    logic        w_flush_any;

    mem_lane_fmt u_lane_fmt (
        .i_st_size    (mem_size_i),
        .i_st_addr_lo (mem_addr_i[1:0]),
        .i_st_wdata   (mem_wdata_i),
        .o_st_be      (w_st_be),
        .o_st_wdata   (w_st_wdata),
        .i_ld_size    (r_size),
        .i_ld_addr_lo (r_addr_lo),
        .i_ld_signed  (r_signed),
        .i_ld_rdata   (bus_rdata_i),
        .o_ld_data    (w_ld_data)
    );

`ifdef MEM_ALIGN_EXC_EN
    assign w_misaligned = is_misaligned(mem_size_i, mem_addr_i[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    // A flush arriving on the completing cycle still counts as a flush.
    assign w_flush_any = r_flushed | flush_i;

    // Stall is combinational so the pipeline freezes in the request cycle.
    assign stallreq_o = ~rst & (((r_state == ST_IDLE) & mem_req_i & ~flush_i) |
                                (r_state == ST_BUS));

    assign bus_req_o   = r_bus_req;
    assign bus_we_o    = r_bus_we;
    assign bus_addr_o  = r_bus_addr;
    assign bus_be_o    = r_bus_be;
    assign bus_wdata_o = r_bus_wdata;
    assign done_o      = r_done;
    assign rdata_o     = r_rdata;
    assign bus_err_o   = r_bus_err;
    assign addr_exc_o  = r_addr_exc;

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_flushed_nxt   = r_flushed;
        w_size_nxt      = r_size;
        w_signed_nxt    = r_signed;
        w_addr_lo_nxt   = r_addr_lo;
        w_bus_req_nxt   = r_bus_req;
        w_bus_we_nxt    = r_bus_we;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_be_nxt    = r_bus_be;
        w_bus_wdata_nxt = r_bus_wdata;
        w_done_nxt      = 1'b0;
        w_rdata_nxt     = r_rdata;
        w_bus_err_nxt   = 1'b0;
        w_addr_exc_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_req_i && !flush_i) begin
                    w_size_nxt    = mem_size_i;
                    w_signed_nxt  = mem_signed_i;
                    w_addr_lo_nxt = mem_addr_i[1:0];
                    if (w_misaligned) begin
                        // Trapped access: no bus cycle, complete straight away.
                        w_state_nxt    = ST_DONE;
                        w_done_nxt     = 1'b1;
                        w_addr_exc_nxt = 1'b1;
                        w_rdata_nxt    = 32'h0000_0000;
                    end else begin
                        w_state_nxt     = ST_BUS;
                        w_cnt_nxt       = 8'd0;
                        w_flushed_nxt   = 1'b0;
                        w_bus_req_nxt   = 1'b1;
                        w_bus_we_nxt    = mem_we_i;
                        w_bus_addr_nxt  = {mem_addr_i[31:2], 2'b00};
                        w_bus_be_nxt    = w_st_be;
                        w_bus_wdata_nxt = w_st_wdata;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUS: begin
                w_flushed_nxt = w_flush_any;
                if (bus_ack_i) begin
                    // Ack is checked first so it wins over a same-cycle timeout.
                    w_bus_req_nxt = 1'b0;
                    w_bus_we_nxt  = 1'b0;
                    w_bus_be_nxt  = 4'b0000;
                    if (w_flush_any) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                        w_rdata_nxt = r_bus_we ? 32'h0000_0000 : w_ld_data;
                    end
                end else if (r_cnt == (TIMEOUT_LIMIT - 8'd1)) begin
                    w_cnt_nxt     = TIMEOUT_LIMIT;
                    w_bus_req_nxt = 1'b0;
                    w_bus_we_nxt  = 1'b0;
                    w_bus_be_nxt  = 4'b0000;
                    if (w_flush_any) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt   = ST_DONE;
                        w_done_nxt    = 1'b1;
                        w_bus_err_nxt = 1'b1;
                        w_rdata_nxt   = 32'h0000_0000;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_DONE: begin
                // The same instruction is still on mem_req_i here; ignore it.
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_bus_req_nxt = 1'b0;
                w_bus_we_nxt  = 1'b0;
            end
        endcase
    end

    // State, capture and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_flushed   <= 1'b0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0000_0000;
            r_bus_be    <= 4'b0000;
            r_bus_wdata <= 32'h0000_0000;
            r_done      <= 1'b0;
            r_rdata     <= 32'h0000_0000;
            r_bus_err   <= 1'b0;
            r_addr_exc  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_flushed   <= w_flushed_nxt;
            r_size      <= w_size_nxt;
            r_signed    <= w_signed_nxt;
            r_addr_lo   <= w_addr_lo_nxt;
            r_bus_req   <= w_bus_req_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_be    <= w_bus_be_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_done      <= w_done_nxt;
            r_rdata     <= w_rdata_nxt;
            r_bus_err   <= w_bus_err_nxt;
            r_addr_exc  <= w_addr_exc_nxt;
        end
    end

endmodule
